// File: rtl/gtp_frame_pkg.sv
// Shared framing constants and types for the GTP TX framer and RX deframer.
// Byte 0 carries the K character on every control word.
package gtp_frame_pkg;

    localparam logic [31:0] IDLE_W = 32'h4A4A_4ABC;
    localparam logic [3:0]  IDLE_K = 4'b0001;
    localparam logic [31:0] SOF_W  = 32'h5050_50FB;
    localparam logic [3:0]  SOF_K  = 4'b0001;
    localparam logic [31:0] EOF_W  = 32'h5050_50FD;
    localparam logic [3:0]  EOF_K  = 4'b0001;
    localparam logic [31:0] CC_W   = 32'hF7F7_F7F7;
    localparam logic [3:0]  CC_K   = 4'b1111;
    localparam logic [3:0]  DATA_K = 4'b0000;

    localparam int TRL_CNT_W = 16;
    localparam int TRL_SUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_EOF,
        ST_CC
    } fr_state_e;

endpackage

// File: rtl/gtp_cc_timer.sv
// Free-running clock-correction timer with a sticky request.
// A new expiry wins over a clear arriving in the same cycle.
module gtp_cc_timer #(
    parameter int unsigned CC_PERIOD = 5000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cc_clr,
    output logic cc_req
);

    localparam int TW = $clog2(CC_PERIOD);
    localparam logic [TW-1:0] RELOAD = TW'(CC_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          req_q, req_d;
    logic          expire;

    // Count down, reload on zero and latch the request until serviced.
    always_comb begin
        expire  = (timer_q == '0);
        timer_d = expire ? RELOAD : timer_q - TW'(1);
        req_d   = expire | (req_q & ~cc_clr);
    end

    // Timer and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= RELOAD;
            req_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    assign cc_req = req_q;

endmodule

// File: rtl/gtp_tx_framer.sv
// Frames the packager word stream for the GTP transmitter: SOF, data,
// trailer {count,sum}, EOF, comma idles and clock-correction runs.
module gtp_tx_framer
    import gtp_frame_pkg::*;
#(
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 4,
    parameter int unsigned MAX_FRAME = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_enable,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    output logic [31:0] gtp_txdata,
    output logic [3:0]  gtp_txcharisk,
    output logic [31:0] frame_cnt,
    output logic        cc_active
);

    localparam logic [3:0] CC_LEN_C = 4'(CC_LEN);
    localparam logic [TRL_CNT_W-1:0] MAX_C = TRL_CNT_W'(MAX_FRAME);

    fr_state_e state_q, state_d, ret_q, ret_d, eff_st;
    logic [TRL_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [TRL_SUM_W-1:0] sum_q, sum_d;
    logic [3:0]  cc_cnt_q, cc_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  txk_q, txk_d;
    logic        cc_req, cc_clr, cc_done, eff_req, room;

    gtp_cc_timer #(
        .CC_PERIOD (CC_PERIOD)
    ) u_cc_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .cc_clr (cc_clr),
        .cc_req (cc_req)
    );

    // Next state and output word; the last CC cycle runs the return
    // state's rules with the request already treated as serviced.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        word_cnt_d  = word_cnt_q;
        sum_d       = sum_q;
        cc_cnt_d    = cc_cnt_q;
        frame_cnt_d = frame_cnt_q;
        txdata_d    = IDLE_W;
        txk_d       = IDLE_K;
        cc_done     = (state_q == ST_CC) && (cc_cnt_q >= CC_LEN_C);
        eff_st      = cc_done ? ret_q : state_q;
        eff_req     = cc_req && !cc_done;
        room        = (word_cnt_q < MAX_C);
        s_tready    = (eff_st == ST_DATA) && !eff_req && room;
        cc_clr      = cc_done;
        case (eff_st)
            ST_IDLE: begin
                if (eff_req) begin
                    txdata_d = CC_W;
                    txk_d    = CC_K;
                    cc_cnt_d = 4'd1;
                    ret_d    = ST_IDLE;
                    state_d  = ST_CC;
                end else if (s_tvalid && tx_enable) begin
                    txdata_d   = SOF_W;
                    txk_d      = SOF_K;
                    word_cnt_d = '0;
                    sum_d      = '0;
                    state_d    = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (eff_req) begin
                    txdata_d = CC_W;
                    txk_d    = CC_K;
                    cc_cnt_d = 4'd1;
                    ret_d    = ST_DATA;
                    state_d  = ST_CC;
                end else if (s_tvalid && room) begin
                    txdata_d   = s_tdata;
                    txk_d      = DATA_K;
                    word_cnt_d = word_cnt_q + TRL_CNT_W'(1);
                    sum_d      = sum_q + s_tdata[31:16] + s_tdata[15:0];
                    state_d    = ST_DATA;
                end else begin
                    txdata_d = {word_cnt_q, sum_q};
                    txk_d    = DATA_K;
                    state_d  = ST_EOF;
                end
            end
            ST_EOF: begin
                txdata_d    = EOF_W;
                txk_d       = EOF_K;
                frame_cnt_d = frame_cnt_q + 32'd1;
                state_d     = ST_IDLE;
            end
            ST_CC: begin
                txdata_d = CC_W;
                txk_d    = CC_K;
                cc_cnt_d = cc_cnt_q + 4'd1;
            end
            default: ;
        endcase
    end

    // State, counters and the registered TX word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            word_cnt_q  <= '0;
            sum_q       <= '0;
            cc_cnt_q    <= '0;
            frame_cnt_q <= '0;
            txdata_q    <= IDLE_W;
            txk_q       <= IDLE_K;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            word_cnt_q  <= word_cnt_d;
            sum_q       <= sum_d;
            cc_cnt_q    <= cc_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            txdata_q    <= txdata_d;
            txk_q       <= txk_d;
        end
    end

    assign gtp_txdata    = txdata_q;
    assign gtp_txcharisk = txk_q;
    assign frame_cnt     = frame_cnt_q;
    assign cc_active     = (state_q == ST_CC);

endmodule

// File: tb/tb_gtp_tx_framer.sv
// Bench for gtp_tx_framer: directed vector table plus a random run
// checked by a stream parser that rebuilds frames from accepted words.
module tb_gtp_tx_framer;
    import gtp_frame_pkg::*;

    localparam int P = 20;
    localparam int L = 4;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_enable = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic [31:0] gtp_txdata;
    logic [3:0]  gtp_txcharisk;
    logic [31:0] frame_cnt;
    logic        cc_active;

    always #5 clk = ~clk;

    gtp_tx_framer #(
        .CC_PERIOD (P),
        .CC_LEN    (L),
        .MAX_FRAME (M)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_enable     (tx_enable),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .gtp_txdata    (gtp_txdata),
        .gtp_txcharisk (gtp_txcharisk),
        .frame_cnt     (frame_cnt),
        .cc_active     (cc_active)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] d;
        bit          en;
        bit          tr;
        logic [31:0] xd;
        logic [3:0]  xk;
        logic [31:0] xfc;
        bit          xcc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit v, logic [31:0] d, bit en,
                                bit tr, logic [31:0] xd, logic [3:0] xk,
                                logic [31:0] xfc, bit xcc);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.en = en; r.tr = tr;
        r.xd = xd; r.xk = xk; r.xfc = xfc; r.xcc = xcc;
        tbl.push_back(r);
    endfunction

    task automatic do_reset();
        s_tvalid  = 1'b0;
        tx_enable = 1'b0;
        s_tdata   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_txdata", gtp_txdata, IDLE_W);
        chk("rst_charisk", 32'(gtp_txcharisk), 32'(IDLE_K));
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_cc_active", 32'(cc_active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [31:0] d, input bit en,
                        output bit tr, output logic [31:0] od,
                        output logic [3:0] ok, output logic [31:0] ofc,
                        output bit occ);
        s_tvalid  = v;
        s_tdata   = d;
        tx_enable = en;
        #1;
        tr = s_tready;
        @(posedge clk);
        #1;
        od  = gtp_txdata;
        ok  = gtp_txcharisk;
        ofc = frame_cnt;
        occ = cc_active;
        @(negedge clk);
    endtask

    // Stream parser state for the random run.
    logic [31:0] acc[$];
    bit          in_frame, has_p, pend;
    logic [31:0] p;
    logic [15:0] cnt, sum;
    int          run, runs, fcx, e, last_exp;

    task automatic commit_data();
        logic [31:0] x;
        x = (acc.size() != 0) ? acc.pop_front() : 32'hx;
        chk("data_order", p, x);
        cnt = cnt + 16'd1;
        sum = sum + p[31:16] + p[15:0];
        chk("frame_len_le_max", 32'(cnt <= 16'(M)), 32'd1);
    endtask

    task automatic parse(input logic [31:0] od, input logic [3:0] ok,
                         input logic [31:0] ofc, input bit occ);
        if (od == CC_W && ok == CC_K) begin
            if (run == 0) begin
                chk("cc_start_pending", 32'(pend), 32'd1);
                chk("cc_latency_1_2",
                    32'((e - last_exp) >= 1 && (e - last_exp) <= 2), 32'd1);
                pend = 1'b0;
                runs++;
            end
            run++;
            chk("cc_active_on_cc", 32'(occ), 32'd1);
        end else begin
            if (run != 0) begin
                chk("cc_run_len", 32'(run), 32'(L));
                run = 0;
            end
            if (od == IDLE_W && ok == IDLE_K) begin
                chk("idle_outside_frame", 32'(in_frame), 32'd0);
            end else if (od == SOF_W && ok == SOF_K) begin
                chk("sof_outside_frame", 32'(in_frame), 32'd0);
                in_frame = 1'b1;
                has_p = 1'b0;
                cnt = '0;
                sum = '0;
            end else if (ok == DATA_K) begin
                chk("data_in_frame", 32'(in_frame), 32'd1);
                if (has_p) commit_data();
                p = od;
                has_p = 1'b1;
            end else if (od == EOF_W && ok == EOF_K) begin
                chk("eof_after_trailer", 32'(in_frame && has_p), 32'd1);
                chk("trailer", p, {cnt, sum});
                fcx++;
                chk("frame_cnt", ofc, 32'(fcx));
                in_frame = 1'b0;
                has_p = 1'b0;
            end else begin
                chk("legal_word", od, IDLE_W);
            end
        end
        if (e % P == P - 1) begin
            last_exp = e;
            pend = 1'b1;
        end
        e++;
    endtask

    initial begin
        bit          tr, occ, v, en;
        logic [31:0] od, ofc, d;
        logic [3:0]  ok;

        // Single frame of three words.
        add(1, 1, 32'hC001_0001, 1, 0, SOF_W, SOF_K, 0, 0);
        add(0, 1, 32'hC001_0001, 1, 1, 32'hC001_0001, DATA_K, 0, 0);
        add(0, 1, 32'hC001_0002, 1, 1, 32'hC001_0002, DATA_K, 0, 0);
        add(0, 1, 32'hC001_0003, 1, 1, 32'hC001_0003, DATA_K, 0, 0);
        add(0, 0, 32'h0, 1, 1, 32'h0003_4009, DATA_K, 0, 0);
        add(0, 0, 32'h0, 1, 0, EOF_W, EOF_K, 1, 0);
        add(0, 0, 32'h0, 1, 0, IDLE_W, IDLE_K, 1, 0);
        add(0, 0, 32'h0, 1, 0, IDLE_W, IDLE_K, 1, 0);
        // Six words against MAX_FRAME=4, with 16-bit sum wrap.
        add(1, 1, 32'hFFFF_FFFF, 1, 0, SOF_W, SOF_K, 0, 0);
        add(0, 1, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, DATA_K, 0, 0);
        add(0, 1, 32'h0001_0002, 1, 1, 32'h0001_0002, DATA_K, 0, 0);
        add(0, 1, 32'h1234_4321, 1, 1, 32'h1234_4321, DATA_K, 0, 0);
        add(0, 1, 32'h8000_8000, 1, 1, 32'h8000_8000, DATA_K, 0, 0);
        add(0, 1, 32'h0000_0001, 1, 0, 32'h0004_5556, DATA_K, 0, 0);
        add(0, 1, 32'h0000_0001, 1, 0, EOF_W, EOF_K, 1, 0);
        add(0, 1, 32'h0000_0001, 1, 0, SOF_W, SOF_K, 1, 0);
        add(0, 1, 32'h0000_0001, 1, 1, 32'h0000_0001, DATA_K, 1, 0);
        add(0, 1, 32'hABCD_0000, 1, 1, 32'hABCD_0000, DATA_K, 1, 0);
        add(0, 0, 32'h0, 1, 1, 32'h0002_ABCE, DATA_K, 1, 0);
        add(0, 0, 32'h0, 1, 0, EOF_W, EOF_K, 2, 0);
        add(0, 0, 32'h0, 1, 0, IDLE_W, IDLE_K, 2, 0);
        // Clock correction lands inside a frame.
        for (int i = 0; i < 16; i++)
            add(i == 0, 0, 32'h0, 1, 0, IDLE_W, IDLE_K, 0, 0);
        add(0, 1, 32'h0001_0001, 1, 0, SOF_W, SOF_K, 0, 0);
        add(0, 1, 32'h0001_0001, 1, 1, 32'h0001_0001, DATA_K, 0, 0);
        add(0, 1, 32'h0002_0002, 1, 1, 32'h0002_0002, DATA_K, 0, 0);
        add(0, 1, 32'h0003_0003, 1, 1, 32'h0003_0003, DATA_K, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 32'h0004_0004, 1, 0, CC_W, CC_K, 0, 1);
        add(0, 1, 32'h0004_0004, 1, 1, 32'h0004_0004, DATA_K, 0, 0);
        add(0, 0, 32'h0, 1, 0, 32'h0004_0014, DATA_K, 0, 0);
        add(0, 0, 32'h0, 1, 0, EOF_W, EOF_K, 1, 0);
        add(0, 0, 32'h0, 1, 0, IDLE_W, IDLE_K, 1, 0);
        // tx_enable low: only idles and clock correction.
        for (int i = 0; i < 20; i++)
            add(i == 0, 1, 32'h1111_1111, 0, 0, IDLE_W, IDLE_K, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, 32'h1111_1111, 0, 0, CC_W, CC_K, 0, 1);
        add(0, 1, 32'h1111_1111, 0, 0, IDLE_W, IDLE_K, 0, 0);
        add(0, 1, 32'h1111_1111, 0, 0, IDLE_W, IDLE_K, 0, 0);
        // tx_enable dropped mid-frame: frame still completes.
        add(1, 1, 32'h0000_0010, 1, 0, SOF_W, SOF_K, 0, 0);
        add(0, 1, 32'h0000_0010, 0, 1, 32'h0000_0010, DATA_K, 0, 0);
        add(0, 1, 32'h0020_0000, 0, 1, 32'h0020_0000, DATA_K, 0, 0);
        add(0, 0, 32'h0, 0, 1, 32'h0002_0030, DATA_K, 0, 0);
        add(0, 1, 32'h0000_0099, 0, 0, EOF_W, EOF_K, 1, 0);
        add(0, 1, 32'h0000_0099, 0, 0, IDLE_W, IDLE_K, 1, 0);
        add(0, 1, 32'h0000_0099, 0, 0, IDLE_W, IDLE_K, 1, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].v, tbl[i].d, tbl[i].en, tr, od, ok, ofc, occ);
            chk($sformatf("vec%0d_tready", i), 32'(tr), 32'(tbl[i].tr));
            chk($sformatf("vec%0d_txdata", i), od, tbl[i].xd);
            chk($sformatf("vec%0d_charisk", i), 32'(ok), 32'(tbl[i].xk));
            chk($sformatf("vec%0d_frame_cnt", i), ofc, tbl[i].xfc);
            chk($sformatf("vec%0d_cc_active", i), 32'(occ), 32'(tbl[i].xcc));
        end

        // Async reset in the middle of a frame.
        do_reset();
        step(1, 32'hDEAD_0001, 1, tr, od, ok, ofc, occ);
        chk("ar_sof", od, SOF_W);
        step(1, 32'hDEAD_0001, 1, tr, od, ok, ofc, occ);
        step(1, 32'hDEAD_0002, 1, tr, od, ok, ofc, occ);
        chk("ar_data2", od, 32'hDEAD_0002);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_async_txdata", gtp_txdata, IDLE_W);
        chk("ar_async_charisk", 32'(gtp_txcharisk), 32'(IDLE_K));
        chk("ar_async_tready", 32'(s_tready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("ar_hold_txdata", gtp_txdata, IDLE_W);
        chk("ar_hold_frame_cnt", frame_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h0005_0007, 1, tr, od, ok, ofc, occ);
        chk("ar2_sof", od, SOF_W);
        step(1, 32'h0005_0007, 1, tr, od, ok, ofc, occ);
        chk("ar2_data", od, 32'h0005_0007);
        step(0, 32'h0, 1, tr, od, ok, ofc, occ);
        chk("ar2_trailer", od, 32'h0001_000C);
        step(0, 32'h0, 1, tr, od, ok, ofc, occ);
        chk("ar2_eof", od, EOF_W);
        chk("ar2_frame_cnt", ofc, 32'd1);

        // Random traffic against the stream parser.
        do_reset();
        in_frame = 0; has_p = 0; pend = 0;
        run = 0; runs = 0; fcx = 0; e = 0; last_exp = -100;
        cnt = '0; sum = '0; p = '0;
        for (int i = 0; i < 2000; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            en = ($urandom_range(0, 19) != 0);
            d  = $urandom;
            step(v, d, en, tr, od, ok, ofc, occ);
            if (v && tr) acc.push_back(d);
            parse(od, ok, ofc, occ);
        end
        for (int i = 0; i < 30; i++) begin
            step(0, 32'h0, 0, tr, od, ok, ofc, occ);
            parse(od, ok, ofc, occ);
        end
        for (int i = 0; i < P && (e % P) != 5; i++) begin
            step(0, 32'h0, 0, tr, od, ok, ofc, occ);
            parse(od, ok, ofc, occ);
        end
        chk("rnd_frames_closed", 32'(in_frame), 32'd0);
        chk("rnd_queue_drained", 32'(acc.size()), 32'd0);
        chk("rnd_cc_serviced", 32'(pend), 32'd0);
        chk("rnd_cc_runs", 32'(runs), 32'((e - 1) / P));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
